fuel_price_dispenser: RTL and testbench

Parametrised successor to the single-rate mini price counter. It runs a dispense session state machine that drives the pump relay and advances the running price by PRICE_STEP on every metering tick. It supports a preset price limit with auto-stop, pause/resume on pump-enable loss, and saturation. It sits between the keypad/preset logic and the relay driver and 7-segment price display.

---
 rtl/fuel_price_dispenser.sv | 158 +++++++++++++++
 tb/tb_fuel_price_dispenser.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fuel_price_dispenser.sv
// Dispense session controller: drives the pump relay and accumulates price per metering tick.
// Optional tick-based volume counter enabled by defining VOLUME_COUNT_EN.
module fuel_price_dispenser #(
   parameter int TICK_CYCLES = 1704545,
   parameter int PRICE_W     = 17,
   parameter int PRICE_STEP  = 1000,
   parameter int VOL_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               start,
   input  logic               stop,
   input  logic               pump_en,
   input  logic [PRICE_W-1:0] preset_price,
   output logic               relay_on,
   output logic [PRICE_W-1:0] price_total,
   output logic               done,
   output logic [1:0]         state,
   output logic               tick
`ifdef VOLUME_COUNT_EN
   ,
   output logic [VOL_W-1:0]   volume_total
`endif
);

   // state | meaning
   // IDLE  | no session, relay off, waiting for start
   // PUMP  | relay on, interval counter running, price accumulating
   // HOLD  | paused on pump_en loss, counter frozen, price held
   // DONE  | session ended (stop, preset reached or saturation), waits for clear
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUMP = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [PRICE_W:0]   STEP_EXT = (PRICE_W+1)'(PRICE_STEP);

   state_t             st, st_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [PRICE_W-1:0] preset_q, preset_nxt;
   logic [PRICE_W-1:0] price_nxt;
   logic [PRICE_W:0]   sum;
   logic               tick_nxt;
   logic               limit_hit;
   logic               auto_stop;
`ifdef VOLUME_COUNT_EN
   logic [VOL_W-1:0]   vol_nxt;
`endif

   // one extra bit so overflow past all-ones is visible
   assign sum       = {1'b0, price_total} + STEP_EXT;
   assign limit_hit = (preset_q != '0) && (sum >= {1'b0, preset_q});
   assign state     = st;

   always_comb begin
      st_nxt     = st;
      cnt_nxt    = cnt;
      price_nxt  = price_total;
      preset_nxt = preset_q;
      tick_nxt   = 1'b0;
      auto_stop  = 1'b0;
`ifdef VOLUME_COUNT_EN
      vol_nxt    = volume_total;
`endif
      case (st)
         IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               preset_nxt = preset_price;
               price_nxt  = '0;
`ifdef VOLUME_COUNT_EN
               vol_nxt    = '0;
`endif
               st_nxt     = pump_en ? PUMP : HOLD;
            end
         end
         PUMP: begin
            if (cnt == CNT_LAST) begin
               tick_nxt = 1'b1;
               cnt_nxt  = '0;
               if (limit_hit) begin
                  price_nxt = preset_q;
                  auto_stop = 1'b1;
               end else if (sum[PRICE_W]) begin
                  price_nxt = '1;
                  auto_stop = 1'b1;
               end else begin
                  price_nxt = sum[PRICE_W-1:0];
               end
`ifdef VOLUME_COUNT_EN
               if (volume_total != '1)
                  vol_nxt = volume_total + 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
            if (auto_stop || stop)
               st_nxt = DONE;
            else if (!pump_en)
               st_nxt = HOLD;
         end
         HOLD: begin
            if (stop)
               st_nxt = DONE;
            else if (pump_en)
               st_nxt = PUMP;
         end
         DONE: begin
            cnt_nxt = '0;
         end
         default: st_nxt = IDLE;
      endcase

      // operator clear overrides everything in the same cycle, including a pending tick
      if (clear) begin
         st_nxt     = IDLE;
         cnt_nxt    = '0;
         price_nxt  = '0;
         preset_nxt = '0;
         tick_nxt   = 1'b0;
`ifdef VOLUME_COUNT_EN
         vol_nxt    = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st           <= IDLE;
         cnt          <= '0;
         preset_q     <= '0;
         price_total  <= '0;
         tick         <= 1'b0;
         relay_on     <= 1'b0;
         done         <= 1'b0;
`ifdef VOLUME_COUNT_EN
         volume_total <= '0;
`endif
      end else begin
         st           <= st_nxt;
         cnt          <= cnt_nxt;
         preset_q     <= preset_nxt;
         price_total  <= price_nxt;
         tick         <= tick_nxt;
         relay_on     <= (st_nxt == PUMP);
         done         <= (st_nxt == DONE);
`ifdef VOLUME_COUNT_EN
         volume_total <= vol_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_fuel_price_dispenser.sv
// Scoreboard bench for fuel_price_dispenser: expected tick prices queued at stimulus time.
// A narrow second instance (PRICE_W=11) shares the stimulus to exercise saturation.
module tb_fuel_price_dispenser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        start;
   logic        stop;
   logic        pump_en;
   logic [16:0] preset_price;

   logic        relay_on,  relay_on2;
   logic [16:0] price_total;
   logic [10:0] price_total2;
   logic        done, done2;
   logic [1:0]  state, state2;
   logic        tick, tick2;
`ifdef VOLUME_COUNT_EN
   logic [15:0] volume_total, volume_total2;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int gap;

   always #5 clk = ~clk;

   fuel_price_dispenser #(
      .TICK_CYCLES(4), .PRICE_W(17), .PRICE_STEP(1000), .VOL_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop),
      .pump_en(pump_en), .preset_price(preset_price),
      .relay_on(relay_on), .price_total(price_total), .done(done),
      .state(state), .tick(tick)
`ifdef VOLUME_COUNT_EN
      , .volume_total(volume_total)
`endif
   );

   fuel_price_dispenser #(
      .TICK_CYCLES(4), .PRICE_W(11), .PRICE_STEP(1000), .VOL_W(16)
   ) dut_narrow (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop),
      .pump_en(pump_en), .preset_price(preset_price[10:0]),
      .relay_on(relay_on2), .price_total(price_total2), .done(done2),
      .state(state2), .tick(tick2)
`ifdef VOLUME_COUNT_EN
      , .volume_total(volume_total2)
`endif
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // one clock; outputs sampled 1 time unit after the edge, every tick popped against the queue
   task automatic cyc();
      @(posedge clk);
      #1;
      if (tick) begin
         if (exp_q.size() == 0)
            check_val("spurious_tick", 1, 0);
         else
            check_val("tick_price", int'(price_total), exp_q.pop_front());
      end
   endtask

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         cyc();
         cycles++;
      end while (!tick && cycles < 20);
      if (!tick)
         check_val("tick_timeout", cycles, 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
      pump_en = 1'b0; preset_price = '0;
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      check_val("rst_state", state, 0);
      check_val("rst_relay", relay_on, 0);
      check_val("rst_price", price_total, 0);
      check_val("rst_done", done, 0);

      // stop is ignored in IDLE
      stop = 1'b1; cyc(); stop = 1'b0;
      check_val("idle_stop_ignored", state, 0);

      // unlimited session, three ticks, then stop
      pump_en = 1'b1;
      preset_price = 17'd0;
      exp_q.push_back(1000); exp_q.push_back(2000); exp_q.push_back(3000);
      pulse_start();
      check_val("start_state", state, 1);
      check_val("start_relay", relay_on, 1);
`ifdef VOLUME_COUNT_EN
      check_val("start_volume", volume_total, 0);
`endif
      for (int i = 0; i < 3; i++) begin
         wait_tick(gap);
         check_val("tick_gap", gap, 4);
         if (i == 1) check_val("narrow_no_sat", price_total2, 2000);
      end
      check_val("narrow_sat_price", price_total2, 2047);
      check_val("narrow_sat_state", state2, 3);
      check_val("narrow_sat_relay", relay_on2, 0);
`ifdef VOLUME_COUNT_EN
      check_val("volume_3", volume_total, 3);
`endif
      stop = 1'b1; cyc(); stop = 1'b0;
      check_val("stop_state", state, 3);
      check_val("stop_relay", relay_on, 0);
      check_val("stop_done", done, 1);
      check_val("stop_price", price_total, 3000);
      pulse_start();
      cyc(); cyc();
      check_val("done_start_ignored", state, 3);
      check_val("done_price_held", price_total, 3000);

      // preset auto-stop; preset changed after start must not matter
      do_clear();
      check_val("clear_state", state, 0);
      check_val("clear_price", price_total, 0);
      check_val("clear_done", done, 0);
      preset_price = 17'd2500;
      exp_q.push_back(1000); exp_q.push_back(2000); exp_q.push_back(2500);
      pulse_start();
      preset_price = 17'd1500;
      for (int i = 0; i < 3; i++) begin
         wait_tick(gap);
         check_val("preset_gap", gap, 4);
      end
      check_val("preset_state", state, 3);
      check_val("preset_relay", relay_on, 0);
      check_val("preset_done", done, 1);

      // pause one cycle after a tick, resume after ten HOLD cycles
      do_clear();
      preset_price = 17'd0;
      exp_q.push_back(1000); exp_q.push_back(2000);
      pulse_start();
`ifdef VOLUME_COUNT_EN
      check_val("restart_volume", volume_total, 0);
`endif
      wait_tick(gap);
      cyc();
      pump_en = 1'b0;
      cyc();
      check_val("hold_state", state, 2);
      check_val("hold_relay", relay_on, 0);
      for (int i = 0; i < 10; i++) cyc();
      check_val("hold_price", price_total, 1000);
      check_val("hold_still", state, 2);
      pump_en = 1'b1;
      cyc();
      check_val("resume_state", state, 1);
      check_val("resume_relay", relay_on, 1);
      wait_tick(gap);
      check_val("resume_gap", gap, 2);
`ifdef VOLUME_COUNT_EN
      check_val("volume_2", volume_total, 2);
`endif

      // clear beats start, stop and a tick in the same cycle
      cyc(); cyc(); cyc();
      clear = 1'b1; start = 1'b1; stop = 1'b1;
      cyc();
      clear = 1'b0; start = 1'b0; stop = 1'b0;
      check_val("clr_pri_state", state, 0);
      check_val("clr_pri_price", price_total, 0);
      check_val("clr_pri_relay", relay_on, 0);
      check_val("clr_pri_done", done, 0);
      check_val("clr_pri_tick", tick, 0);
      cyc(); cyc();
      check_val("clr_start_ignored", state, 0);

      // reset in the middle of HOLD
      exp_q.push_back(1000);
      pulse_start();
      wait_tick(gap);
      pump_en = 1'b0;
      cyc();
      check_val("hold2_state", state, 2);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check_val("rst_hold_state", state, 0);
      check_val("rst_hold_price", price_total, 0);
      check_val("rst_hold_relay", relay_on, 0);
      check_val("rst_hold_done", done, 0);
      check_val("rst_hold_tick", tick, 0);
`ifdef VOLUME_COUNT_EN
      check_val("rst_hold_volume", volume_total, 0);
`endif
      cyc(); cyc();
      check_val("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
